set_assoc_cache: RTL and testbench
==================================

// Module: set_assoc_cache
// PURPOSE
//   Parametrised N-way set-associative, write-back, write-allocate data cache between the CPU load/store
//   unit and main memory. Successor to the fixed 4-line fully-associative cache: configurable sets, ways
//   and line size, with an explicit miss FSM (victim writeback, then refill) and valid/ready handshakes.
// PARAMETERS
//   WORD_WIDTH      32  CPU data word width (bits, multiple of 8)
//   ADDR_WIDTH      32  byte address width
//   NUM_SETS         4  number of sets (power of 2, >=1)
//   NUM_WAYS         4  ways per set (power of 2, 1..8)
//   WORDS_PER_LINE   4  words per line (power of 2, >=2); LINE_WIDTH = WORD_WIDTH*WORDS_PER_LINE
// PORTS
//   clk         in   1           clock, rising edge
//   reset       in   1           asynchronous, active-high
//   req_valid   in   1           CPU request present
//   req_ready   out  1           cache can accept a request (high only in IDLE)
//   req_op      in   1           0 = write, 1 = read
//   req_byte    in   1           1 = byte access, 0 = full word
//   req_addr    in   ADDR_WIDTH  byte address
//   req_wdata   in   WORD_WIDTH  write data (byte ops use [7:0])
//   resp_valid  out  1           one-cycle pulse: read data valid / write complete
//   resp_rdata  out  WORD_WIDTH  read data; byte reads zero-extended; 0 on write responses
//   mem_req     out  1           memory request, held until mem_ack
//   mem_we      out  1           1 = line write (writeback), 0 = line read (refill)
//   mem_addr    out  ADDR_WIDTH  line-aligned address (offset bits zero)
//   mem_wdata   out  LINE_WIDTH  victim line, word 0 in [WORD_WIDTH-1:0]
//   mem_ack     in   1           one-cycle pulse: write done / mem_rdata valid
//   mem_rdata   in   LINE_WIDTH  refill line, same packing as mem_wdata
// BEHAVIOUR
//   Address split: [byte off | word off | set index | tag], widths log2 of WORD_WIDTH/8, WORDS_PER_LINE, NUM_SETS.
//   Reset: all valid/dirty bits 0, LRU rank of way w = w in every set, FSM = IDLE; req_ready=1,
//     resp_valid=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset mid-miss aborts
//     at once (mem_req drops); the pending request is dropped with no response.
//   FSM states: IDLE, WRITEBACK, REFILL, RESPOND.
//   IDLE: on req_valid&req_ready latch op/byte/addr/wdata and compare tags of all ways in the set.
//     Hit -> perform access, update LRU, resp_valid next cycle (1-cycle hit latency), stay IDLE.
//     Miss, victim clean or invalid -> REFILL. Miss, victim valid&dirty -> WRITEBACK.
//   Victim select: lowest-index invalid way; else way with LRU rank 0.
//   WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag,set,0}, mem_wdata=victim line; on mem_ack
//     clear victim dirty -> REFILL.
//   REFILL: mem_req=1, mem_we=0, mem_addr={req tag,set,0}; on mem_ack install line, tag, valid=1,
//     dirty=0 -> RESPOND. mem_req deasserts the cycle after mem_ack.
//   RESPOND: perform latched access on installed line (write merges req_wdata, sets dirty), update LRU,
//     resp_valid=1 for one cycle -> IDLE. Miss latency = 2 + memory cycles.
//   LRU: per-set ranks 0..NUM_WAYS-1 (NUM_WAYS-1 = MRU); on access, ranks above accessed rank decrement,
//     accessed way <- NUM_WAYS-1. Ranks stay a permutation at all times.
//   Writes: word write replaces selected word; byte write replaces byte lane byte_off only; set dirty=1.
//   req_ready=0 in WRITEBACK/REFILL/RESPOND; req_valid then ignored. mem_ack outside WRITEBACK/REFILL ignored.
//   Back-to-back hits: one request per cycle, responses in order, one cycle after acceptance.
//   Same-set different-tag requests after refill see updated LRU (no stale victim choice).
// TESTING
//   1 Reset, read 0x100, mem returns line {W3..W0}={4,3,2,1} -> one REFILL, resp_rdata=0x2 for addr 0x104.
//   2 Read 0x104 again -> no mem_req, resp_valid 1 cycle after acceptance, data 0x2.
//   3 Byte write 0xAB to 0x101, then word read 0x100 -> 0x0000AB01; byte read 0x101 -> 0x000000AB.
//   4 Fill one set with NUM_WAYS+1 distinct tags, first dirty -> WRITEBACK of first line (mem_we=1,
//     correct addr/data) precedes REFILL; LRU victim is least recently touched way.
//   5 Assert reset while mem_req=1 in REFILL -> outputs at reset values same cycle, no resp_valid,
//     subsequent read of same addr misses.
//   6 Random req/mem_ack-delay stream (0..5 cycles) vs. reference model -> all read data match.

Source files
------------

// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-back, write-allocate data cache with true-LRU replacement.
// A miss evicts a dirty victim in WRITEBACK, fetches the line in REFILL and answers in RESPOND.
module set_assoc_cache #(
    parameter int WORD_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_SETS       = 4,
    parameter int NUM_WAYS       = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_op,
    input  logic                                 req_byte,
    input  logic [ADDR_WIDTH-1:0]                req_addr,
    input  logic [WORD_WIDTH-1:0]                req_wdata,
    output logic                                 resp_valid,
    output logic [WORD_WIDTH-1:0]                resp_rdata,
    output logic                                 mem_req,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] mem_wdata,
    input  logic                                 mem_ack,
    input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] mem_rdata
);

    localparam int LINE_WIDTH = WORD_WIDTH * WORDS_PER_LINE;
    localparam int BYTES      = WORD_WIDTH / 8;
    localparam int BOFF_W     = $clog2(BYTES);
    localparam int BOFF_IW    = (BOFF_W > 0) ? BOFF_W : 1;
    localparam int WOFF_W     = $clog2(WORDS_PER_LINE);
    localparam int SET_BITS   = $clog2(NUM_SETS);
    localparam int SET_W      = (SET_BITS > 0) ? SET_BITS : 1;
    localparam int LINE_OFF_W = BOFF_W + WOFF_W;
    localparam int TAG_W      = ADDR_WIDTH - LINE_OFF_W - SET_BITS;
    localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;

    function automatic logic [SET_W-1:0] set_of(input logic [ADDR_WIDTH-1:0] a);
        return SET_W'((a >> LINE_OFF_W) & ADDR_WIDTH'(NUM_SETS - 1));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_WIDTH-1:0] a);
        return TAG_W'(a >> (LINE_OFF_W + SET_BITS));
    endfunction

    function automatic logic [WOFF_W-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
        return WOFF_W'(a >> BOFF_W);
    endfunction

    function automatic logic [BOFF_IW-1:0] byte_of(input logic [ADDR_WIDTH-1:0] a);
        return BOFF_IW'(a & ADDR_WIDTH'(BYTES - 1));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                        input logic [SET_W-1:0] s);
        return (ADDR_WIDTH'(t) << (LINE_OFF_W + SET_BITS)) | (ADDR_WIDTH'(s) << LINE_OFF_W);
    endfunction

    // Byte reads come back zero-extended from the addressed lane.
    function automatic logic [WORD_WIDTH-1:0] read_word(input logic [LINE_WIDTH-1:0] line,
                                                        input logic [ADDR_WIDTH-1:0] a,
                                                        input logic                  is_byte);
        logic [WORD_WIDTH-1:0] w;
        int wi;
        int bi;
        wi = int'(word_of(a));
        bi = int'(byte_of(a));
        w  = line[wi*WORD_WIDTH +: WORD_WIDTH];
        if (is_byte)
            w = WORD_WIDTH'(w[bi*8 +: 8]);
        return w;
    endfunction

    function automatic logic [LINE_WIDTH-1:0] write_line(input logic [LINE_WIDTH-1:0] line,
                                                         input logic [ADDR_WIDTH-1:0] a,
                                                         input logic                  is_byte,
                                                         input logic [WORD_WIDTH-1:0] wdata);
        logic [LINE_WIDTH-1:0] l;
        int wi;
        int bi;
        l  = line;
        wi = int'(word_of(a));
        bi = int'(byte_of(a));
        if (is_byte)
            l[wi*WORD_WIDTH + bi*8 +: 8] = wdata[7:0];
        else
            l[wi*WORD_WIDTH +: WORD_WIDTH] = wdata;
        return l;
    endfunction

    state_t state;
    state_t next_state;

    logic [LINE_WIDTH-1:0] data_arr  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]      tag_arr   [NUM_SETS][NUM_WAYS];
    logic                  valid_arr [NUM_SETS][NUM_WAYS];
    logic                  dirty_arr [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]      rank_arr  [NUM_SETS][NUM_WAYS];

    logic [SET_W-1:0]      in_set;
    logic [TAG_W-1:0]      in_tag;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim_way;
    logic                  accept;

    logic                  lat_op;
    logic                  lat_byte;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [WORD_WIDTH-1:0] lat_wdata;
    logic [WAY_W-1:0]      lat_way;
    logic [SET_W-1:0]      lat_set;
    logic [TAG_W-1:0]      lat_tag;

    logic                  touch_en;
    logic [SET_W-1:0]      touch_set;
    logic [WAY_W-1:0]      touch_way;

    assign in_set  = set_of(req_addr);
    assign in_tag  = tag_of(req_addr);
    assign lat_set = set_of(lat_addr);
    assign lat_tag = tag_of(lat_addr);
    assign accept  = req_valid && req_ready;

    // Victim: lowest-index invalid way wins over the LRU (rank 0) way.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_arr[in_set][w] && tag_arr[in_set][w] == in_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (rank_arr[in_set][w] == '0)
                victim_way = WAY_W'(w);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_arr[in_set][w])
                victim_way = WAY_W'(w);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && !hit)
                    next_state = (valid_arr[in_set][victim_way] && dirty_arr[in_set][victim_way])
                                 ? WRITEBACK : REFILL;
            end
            WRITEBACK: if (mem_ack) next_state = REFILL;
            REFILL:    if (mem_ack) next_state = RESPOND;
            RESPOND:   next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = line_addr(tag_arr[lat_set][lat_way], lat_set);
                mem_wdata = data_arr[lat_set][lat_way];
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = line_addr(lat_tag, lat_set);
            end
            default: ;
        endcase
    end

    // A hit in IDLE and the deferred access in RESPOND are the only LRU touches.
    always_comb begin
        touch_en  = (state == RESPOND) || (state == IDLE && accept && hit);
        touch_set = (state == RESPOND) ? lat_set : in_set;
        touch_way = (state == RESPOND) ? lat_way : hit_way;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_op    <= 1'b0;
            lat_byte  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_way   <= '0;
        end else if (accept) begin
            lat_op    <= req_op;
            lat_byte  <= req_byte;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_way   <= hit ? hit_way : victim_way;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_arr[s][w] <= 1'b0;
                    dirty_arr[s][w] <= 1'b0;
                    rank_arr[s][w]  <= WAY_W'(w);
                end
            end
        end else begin
            case (state)
                IDLE:      if (accept && hit && !req_op) dirty_arr[in_set][hit_way] <= 1'b1;
                WRITEBACK: if (mem_ack) dirty_arr[lat_set][lat_way] <= 1'b0;
                REFILL: begin
                    if (mem_ack) begin
                        valid_arr[lat_set][lat_way] <= 1'b1;
                        dirty_arr[lat_set][lat_way] <= 1'b0;
                    end
                end
                RESPOND:   if (!lat_op) dirty_arr[lat_set][lat_way] <= 1'b1;
                default: ;
            endcase
            if (touch_en) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == touch_way)
                        rank_arr[touch_set][w] <= WAY_W'(NUM_WAYS - 1);
                    else if (rank_arr[touch_set][w] > rank_arr[touch_set][touch_way])
                        rank_arr[touch_set][w] <= rank_arr[touch_set][w] - 1'b1;
                end
            end
        end
    end

    // Line data and tags need no reset: valid bits gate every use of them.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept && hit && !req_op)
                    data_arr[in_set][hit_way] <= write_line(data_arr[in_set][hit_way],
                                                            req_addr, req_byte, req_wdata);
            end
            REFILL: begin
                if (mem_ack) begin
                    data_arr[lat_set][lat_way] <= mem_rdata;
                    tag_arr[lat_set][lat_way]  <= lat_tag;
                end
            end
            RESPOND: begin
                if (!lat_op)
                    data_arr[lat_set][lat_way] <= write_line(data_arr[lat_set][lat_way],
                                                             lat_addr, lat_byte, lat_wdata);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            if (state == IDLE && accept && hit) begin
                resp_valid <= 1'b1;
                if (req_op)
                    resp_rdata <= read_word(data_arr[in_set][hit_way], req_addr, req_byte);
            end else if (state == RESPOND) begin
                resp_valid <= 1'b1;
                if (lat_op)
                    resp_rdata <= read_word(data_arr[lat_set][lat_way], lat_addr, lat_byte);
            end
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench for set_assoc_cache: directed scenarios plus a random stream checked
// against a flat byte-memory model backed by a line-level main-memory responder.
module tb_set_assoc_cache;

    localparam int LW = 128;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic          req_byte;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_ack;
    logic [LW-1:0] mem_rdata;

    int compared   = 0;
    int mismatched = 0;
    int mem_delay  = 0;
    bit mem_hold   = 0;

    logic [LW-1:0] backing [logic [31:0]];
    logic [7:0]    gold    [logic [31:0]];
    bit            log_we   [$];
    logic [31:0]   log_addr [$];
    logic [LW-1:0] log_data [$];

    set_assoc_cache dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] patWord(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic logic [LW-1:0] getLine(input logic [31:0] la);
        logic [LW-1:0] l;
        if (backing.exists(la))
            return backing[la];
        for (int i = 0; i < 4; i++)
            l[i*32 +: 32] = patWord(la + 32'(i*4));
        return l;
    endfunction

    function automatic logic [7:0] goldByte(input logic [31:0] a);
        logic [31:0] w;
        if (gold.exists(a))
            return gold[a];
        w = patWord({a[31:2], 2'b00});
        return w[8*int'(a[1:0]) +: 8];
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a, input bit isb);
        if (isb)
            return {24'h0, goldByte(a)};
        return {goldByte(a + 3), goldByte(a + 2), goldByte(a + 1), goldByte(a)};
    endfunction

    function automatic void modelWrite(input logic [31:0] a, input bit isb, input logic [31:0] wd);
        if (isb)
            gold[a] = wd[7:0];
        else
            for (int b = 0; b < 4; b++)
                gold[a + 32'(b)] = wd[8*b +: 8];
    endfunction

    // Main-memory responder: acks after mem_delay extra cycles, logs every line transfer.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req && !mem_hold && !reset) begin
                if (wait_cnt < mem_delay) begin
                    wait_cnt++;
                end else begin
                    log_we.push_back(mem_we);
                    log_addr.push_back(mem_addr);
                    log_data.push_back(mem_wdata);
                    if (mem_we)
                        backing[mem_addr] = mem_wdata;
                    else
                        mem_rdata = getLine(mem_addr);
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkLine(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request and waits for its response; lat counts extra cycles past the first.
    task automatic applyStimulus(input logic op, input logic isb, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_byte  = isb;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checkBit("resp_arrived", resp_valid, 1'b1);
        rdata = resp_rdata;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0]   rd;
        logic [LW-1:0] exp_line;
        int            lat;
        int            base;
        int            seen;
        bit            op;
        bit            isb;
        logic [31:0]   addr;
        logic [31:0]   wd;
        logic [31:0]   exp;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        checkBit("rst_req_ready", req_ready, 1'b1);
        checkBit("rst_resp_valid", resp_valid, 1'b0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
        checkBit("rst_mem_req", mem_req, 1'b0);
        checkBit("rst_mem_we", mem_we, 1'b0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkLine("rst_mem_wdata", mem_wdata, '0);
        reset = 1'b0;

        $display("[TB] cold miss and refill");
        backing[32'h100] = {32'd4, 32'd3, 32'd2, 32'd1};
        base = log_addr.size();
        applyStimulus(1'b1, 1'b0, 32'h104, 32'h0, rd, lat);
        checkOutput("t1_rdata", rd, 32'h2);
        checkOutput("t1_mem_txns", 32'(log_addr.size() - base), 32'd1);
        checkOutput("t1_refill_addr", log_addr[base], 32'h100);
        checkBit("t1_refill_read", log_we[base], 1'b0);

        $display("[TB] hit latency and back-to-back hits");
        base = log_addr.size();
        applyStimulus(1'b1, 1'b0, 32'h104, 32'h0, rd, lat);
        checkOutput("t2_rdata", rd, 32'h2);
        checkOutput("t2_latency", 32'(lat), 32'd0);
        checkOutput("t2_no_mem", 32'(log_addr.size() - base), 32'd0);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 32'h100;
        @(negedge clk);
        checkBit("t2_b2b_valid0", resp_valid, 1'b1);
        checkOutput("t2_b2b_data0", resp_rdata, 32'h1);
        req_addr = 32'h108;
        @(negedge clk);
        checkBit("t2_b2b_valid1", resp_valid, 1'b1);
        checkOutput("t2_b2b_data1", resp_rdata, 32'h3);
        req_addr = 32'h10C;
        @(negedge clk);
        checkBit("t2_b2b_valid2", resp_valid, 1'b1);
        checkOutput("t2_b2b_data2", resp_rdata, 32'h4);
        req_valid = 1'b0;
        @(negedge clk);
        checkBit("t2_resp_pulse", resp_valid, 1'b0);

        $display("[TB] byte write merge");
        applyStimulus(1'b0, 1'b1, 32'h101, 32'h000000AB, rd, lat);
        checkOutput("t3_write_resp", rd, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, rd, lat);
        checkOutput("t3_word_read", rd, 32'h0000AB01);
        applyStimulus(1'b1, 1'b1, 32'h101, 32'h0, rd, lat);
        checkOutput("t3_byte_read", rd, 32'h000000AB);

        $display("[TB] set overflow, dirty writeback, LRU victim");
        doReset();
        mem_delay = 1;
        applyStimulus(1'b0, 1'b0, 32'h000, 32'hDEADBEEF, rd, lat);
        checkOutput("t4_write_resp", rd, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h040, 32'h0, rd, lat);
        applyStimulus(1'b1, 1'b0, 32'h080, 32'h0, rd, lat);
        applyStimulus(1'b1, 1'b0, 32'h0C0, 32'h0, rd, lat);
        checkOutput("t4_fill_read", rd, patWord(32'h0C0));
        base = log_addr.size();
        applyStimulus(1'b1, 1'b0, 32'h140, 32'h0, rd, lat);
        checkOutput("t4_evict_rdata", rd, patWord(32'h140));
        checkOutput("t4_evict_txns", 32'(log_addr.size() - base), 32'd2);
        checkBit("t4_wb_first_we", log_we[base], 1'b1);
        checkOutput("t4_wb_addr", log_addr[base], 32'h000);
        exp_line = {patWord(32'hC), patWord(32'h8), patWord(32'h4), 32'hDEADBEEF};
        checkLine("t4_wb_data", log_data[base], exp_line);
        checkBit("t4_refill_we", log_we[base + 1], 1'b0);
        checkOutput("t4_refill_addr", log_addr[base + 1], 32'h140);
        applyStimulus(1'b1, 1'b0, 32'h040, 32'h0, rd, lat);
        base = log_addr.size();
        applyStimulus(1'b1, 1'b0, 32'h180, 32'h0, rd, lat);
        checkOutput("t4_clean_evict_txns", 32'(log_addr.size() - base), 32'd1);
        base = log_addr.size();
        applyStimulus(1'b1, 1'b0, 32'h080, 32'h0, rd, lat);
        checkOutput("t4_lru_victim_missed", 32'(log_addr.size() - base), 32'd1);
        checkOutput("t4_lru_victim_addr", log_addr[base], 32'h080);
        base = log_addr.size();
        applyStimulus(1'b1, 1'b0, 32'h040, 32'h0, rd, lat);
        checkOutput("t4_recent_kept", 32'(log_addr.size() - base), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h000, 32'h0, rd, lat);
        checkOutput("t4_wb_roundtrip", rd, 32'hDEADBEEF);

        $display("[TB] reset during refill");
        doReset();
        mem_hold = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 32'h200;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkBit("t5_mem_req_before", mem_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkBit("t5_mem_req", mem_req, 1'b0);
        checkBit("t5_mem_we", mem_we, 1'b0);
        checkOutput("t5_mem_addr", mem_addr, 32'h0);
        checkLine("t5_mem_wdata", mem_wdata, '0);
        checkBit("t5_req_ready", req_ready, 1'b1);
        checkBit("t5_resp_valid", resp_valid, 1'b0);
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        mem_hold = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        checkOutput("t5_no_resp", 32'(seen), 32'd0);
        base = log_addr.size();
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, rd, lat);
        checkOutput("t5_remiss_txns", 32'(log_addr.size() - base), 32'd1);
        checkOutput("t5_remiss_addr", log_addr[base], 32'h200);
        checkOutput("t5_rdata", rd, patWord(32'h200));

        $display("[TB] random stream against reference model");
        doReset();
        for (int i = 0; i < 300; i++) begin
            op   = 1'($urandom_range(0, 1));
            isb  = 1'($urandom_range(0, 1));
            addr = 32'h1000 + $urandom_range(0, 32'h3FF);
            if (!isb) addr[1:0] = 2'b00;
            wd   = $urandom;
            mem_delay = int'($urandom_range(0, 5));
            applyStimulus(op, isb, addr, wd, rd, lat);
            if (op) begin
                exp = modelRead(addr, isb);
            end else begin
                modelWrite(addr, isb, wd);
                exp = 32'h0;
            end
            checkOutput($sformatf("rand%0d_addr%h", i, addr), rd, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
